// File: rtl/spi_pkg.sv
// Shared types and constants for the oversampling SPI slave.
package spi_pkg;

   localparam int SPI_WIDTH_DEF      = 8;
   localparam int CLK_SCLK_MIN_RATIO = 4;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT
   } spi_slv_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one SPI pin, with rise/fall pulses taken
// against one extra registered copy of the synchronized level.
module spi_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_fd.sv
// Full-duplex SPI mode-0 slave, oversampled in the clk domain.
// Optional SPI_SLAVE_UNDERRUN_EN adds a sticky tx_underrun flag.
module spi_slave_fd
   import spi_pkg::*;
#(
   parameter int WIDTH       = SPI_WIDTH_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sclk,
   input  logic             cs,
   input  logic             mosi,
   output logic             miso,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             busy
`ifdef SPI_SLAVE_UNDERRUN_EN
   ,
   output logic             tx_underrun
`endif
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   spi_slv_state_t   state;
   logic [CNT_W-1:0] bit_cnt;
   logic [WIDTH-1:0] tx_sh;
   logic [WIDTH-1:0] rx_sh;
   logic [WIDTH-1:0] hold_buf;

   logic sclk_lvl_unused, sclk_rise, sclk_fall;
   logic cs_s, cs_rise_unused, cs_fall;
   logic mosi_s, mosi_rise_unused, mosi_fall_unused;
   logic accept, frame_end, do_load, word_done, shift_in, shift_out;

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .din(sclk),
      .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
   );

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
      .clk(clk), .rst_n(rst_n), .din(cs),
      .level(cs_s), .rise(cs_rise_unused), .fall(cs_fall)
   );

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk(clk), .rst_n(rst_n), .din(mosi),
      .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
   );

   // A frame only starts on a cs fall, so a high cs level outside IDLE is the rising edge.
   assign accept    = tx_valid && tx_ready;
   assign frame_end = cs_s && (state != IDLE);
   assign do_load   = (state == LOAD) && !frame_end;
   assign word_done = (state == SHIFT) && !frame_end && (bit_cnt == CNT_W'(WIDTH));
   assign shift_in  = (state == SHIFT) && !frame_end && !word_done && sclk_rise;
   assign shift_out = (state == SHIFT) && !frame_end && !word_done && !sclk_rise
                      && sclk_fall && (bit_cnt != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         miso     <= 1'b0;
         tx_ready <= 1'b1;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         busy     <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (accept)
            tx_ready <= 1'b0;
         else if (do_load)
            tx_ready <= 1'b1;

         if (frame_end) begin
            state   <= IDLE;
            bit_cnt <= '0;
            miso    <= 1'b0;
            busy    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (cs_fall) begin
                     state <= LOAD;
                     busy  <= 1'b1;
                  end
               end
               LOAD: begin
                  miso    <= tx_ready ? 1'b0 : hold_buf[WIDTH-1];
                  bit_cnt <= '0;
                  state   <= SHIFT;
               end
               SHIFT: begin
                  if (word_done) begin
                     rx_data  <= rx_sh;
                     rx_valid <= 1'b1;
                     bit_cnt  <= '0;
                     state    <= LOAD;
                  end else if (shift_in) begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end else if (shift_out) begin
                     miso <= tx_sh[WIDTH-1];
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // tx_sh is kept one bit ahead: its MSB is the bit that goes to miso on the next sclk fall.
   always_ff @(posedge clk) begin
      if (accept)
         hold_buf <= tx_data;
      if (do_load)
         tx_sh <= tx_ready ? '0 : {hold_buf[WIDTH-2:0], 1'b0};
      else if (shift_out)
         tx_sh <= {tx_sh[WIDTH-2:0], 1'b0};
      if (shift_in)
         rx_sh <= {rx_sh[WIDTH-2:0], mosi_s};
   end

`ifdef SPI_SLAVE_UNDERRUN_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tx_underrun <= 1'b0;
      else if (do_load && tx_ready)
         tx_underrun <= 1'b1;
      else if (accept)
         tx_underrun <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_spi_slave_fd.sv
// Scoreboard bench for spi_slave_fd: bench-side SPI master, word-level
// reference model of the tx holding buffer, and an rx_valid monitor.
`timescale 1ns/1ps
module tb_spi_slave_fd;

   localparam int HALF = 5;   // sclk half period in clk cycles (sclk = clk/10)

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk = 1'b0;
   logic       cs = 1'b1;
   logic       mosi = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       miso, tx_ready, rx_valid, busy;
   logic [7:0] rx_data;
`ifdef SPI_SLAVE_UNDERRUN_EN
   logic       tx_underrun;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_rx[$];
   logic [7:0] tx_q[$];
   bit         exp_underrun = 1'b0;

   logic [7:0] f_mo[4];
   bit         f_ld[4];
   logic [7:0] f_ldw[4];
   bit         t6_hold = 1'b0;
   logic [7:0] t6_word = '0;

   always #5 clk = ~clk;

   spi_slave_fd #(.WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
`ifdef SPI_SLAVE_UNDERRUN_EN
      , .tx_underrun(tx_underrun)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_ur();
`ifdef SPI_SLAVE_UNDERRUN_EN
      chk("tx_underrun", {31'd0, tx_underrun}, {31'd0, exp_underrun});
`endif
   endtask

   task automatic clk_wait(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Word start: the holding buffer is handed to the shifter, or zero if nothing is waiting.
   function automatic logic [7:0] pop_tx();
      if (tx_q.size() > 0) return tx_q.pop_front();
      exp_underrun = 1'b1;
      return 8'h00;
   endfunction

   task automatic load_tx(input logic [7:0] w);
      @(negedge clk);
      chk("tx_ready_before_load", {31'd0, tx_ready}, 32'd1);
      tx_data  = w;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      chk("tx_ready_after_load", {31'd0, tx_ready}, 32'd0);
      tx_q.push_back(w);
      exp_underrun = 1'b0;
   endtask

   task automatic xfer_word(input logic [7:0] mo, input int nbits, input bit ld,
                            input logic [7:0] ldw, output logic [7:0] mi);
      mi = '0;
      for (int i = 0; i < nbits; i++) begin
         mosi = mo[7-i];
         clk_wait(HALF);
         sclk = 1'b1;
         mi[7-i] = miso;
         clk_wait(HALF);
         sclk = 1'b0;
         if (i == 3 && ld && tx_q.size() == 0) load_tx(ldw);
      end
   endtask

   task automatic frame(input int nwords, input int last_bits);
      logic [7:0] got, expw;
      int nb;
      cs = 1'b0;
      clk_wait(8);
      if (t6_hold) begin
         tx_valid = 1'b0;
         t6_hold  = 1'b0;
         tx_q.push_back(t6_word);
         exp_underrun = 1'b0;
         chk("tx_ready_new_word_kept", {31'd0, tx_ready}, 32'd0);
      end
      for (int w = 0; w < nwords; w++) begin
         nb   = (w == nwords - 1) ? last_bits : 8;
         expw = pop_tx();
         if (nb == 8) exp_rx.push_back(f_mo[w]);
         xfer_word(f_mo[w], nb, f_ld[w] && (nb == 8), f_ldw[w], got);
         if (nb == 8) chk("miso_word", {24'd0, got}, {24'd0, expw});
      end
      // A completed word always starts the next one while cs stays low.
      if (last_bits == 8) void'(pop_tx());
      clk_wait(HALF);
      cs = 1'b1;
      clk_wait(6);
      chk("busy_after_frame", {31'd0, busy}, 32'd0);
      chk("miso_after_frame", {31'd0, miso}, 32'd0);
      chk("tx_ready_after_frame", {31'd0, tx_ready}, {31'd0, tx_q.size() == 0});
      chk_ur();
   endtask

   always @(negedge clk) begin
      if (rst_n && rx_valid) begin
         if (exp_rx.size() == 0) chk("rx_valid_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
         else chk("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] got;
      int nw, lb;

      clk_wait(3);
      chk("reset_miso", {31'd0, miso}, 32'd0);
      chk("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
      chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
      chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk_ur();
      rst_n = 1'b1;
      clk_wait(4);

      // 1: single word
      load_tx(8'hAA);
      f_mo[0] = 8'h55; f_ld[0] = 1'b0;
      frame(1, 8);

      // 2: two back-to-back words, second tx word loaded mid-word
      load_tx(8'h0F);
      f_mo[0] = 8'h3C; f_ld[0] = 1'b1; f_ldw[0] = 8'hF0;
      f_mo[1] = 8'hC3; f_ld[1] = 1'b0;
      frame(2, 8);

      // 3: aborted after 5 bits, then a full word
      f_mo[0] = 8'h6B; f_ld[0] = 1'b0;
      frame(1, 5);
      f_mo[0] = 8'h81;
      frame(1, 8);
      chk("rx_data_held", {24'd0, rx_data}, 32'h81);

      // 4: nothing loaded -> zeros on miso, underrun until the next accept
      f_mo[0] = 8'hFF; f_ld[0] = 1'b0;
      frame(1, 8);
      load_tx(8'h5A);
      chk_ur();

      // 5: reset mid-frame, cs kept low afterwards
      cs = 1'b0;
      clk_wait(8);
      void'(pop_tx());
      xfer_word(8'hA5, 3, 1'b0, 8'h00, got);
      rst_n = 1'b0;
      #1;
      chk("midreset_miso", {31'd0, miso}, 32'd0);
      chk("midreset_tx_ready", {31'd0, tx_ready}, 32'd1);
      chk("midreset_rx_data", {24'd0, rx_data}, 32'd0);
      chk("midreset_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("midreset_busy", {31'd0, busy}, 32'd0);
      tx_q.delete();
      exp_underrun = 1'b0;
      chk_ur();
      clk_wait(2);
      rst_n = 1'b1;
      xfer_word(8'hFF, 8, 1'b0, 8'h00, got);
      clk_wait(6);
      chk("post_reset_busy", {31'd0, busy}, 32'd0);
      chk("post_reset_miso", {31'd0, miso}, 32'd0);
      cs = 1'b1;
      clk_wait(6);
      f_mo[0] = 8'h96; f_ld[0] = 1'b0;
      frame(1, 8);

      // 6: tx_valid held through LOAD: old word goes out, new word waits
      load_tx(8'hC8);
      tx_data  = 8'h37;
      tx_valid = 1'b1;
      t6_word  = 8'h37;
      t6_hold  = 1'b1;
      clk_wait(3);
      chk("tx_ready_full_hold", {31'd0, tx_ready}, 32'd0);
      f_mo[0] = 8'h12; f_ld[0] = 1'b0;
      f_mo[1] = 8'hED; f_ld[1] = 1'b0;
      frame(2, 8);

      // Randomized frames
      for (int it = 0; it < 30; it++) begin
         nw = $urandom_range(1, 3);
         lb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 8;
         for (int w = 0; w < 4; w++) begin
            f_mo[w]  = 8'($urandom);
            f_ld[w]  = ($urandom_range(0, 3) != 0);
            f_ldw[w] = 8'($urandom);
         end
         if (tx_q.size() == 0 && $urandom_range(0, 1) == 1) load_tx(8'($urandom));
         frame(nw, lb);
      end

      clk_wait(20);
      chk("rx_words_outstanding", exp_rx.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
